button_event_arbiter: RTL

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 15 +
 rtl/event_fifo.sv | 51 +++++
 rtl/button_event_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/button_event_arbiter_pkg.sv
// rtl/button_event_arbiter_pkg.sv - shared constants and clog2 helper for the button event arbiter
package button_event_arbiter_pkg;

  localparam int DROP_CNT_W     = 8;
  localparam int DEF_NUM_BTN    = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous power-of-two event queue with push/pop/full/empty/count
module event_fifo
  import button_event_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter queuing button presses as events, with drop counter
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int NUM_BTN    = DEF_NUM_BTN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BTN-1:0]                btn_pulse,
  input  logic                              evt_ready,
  input  logic                              drop_clr,
  output logic                              evt_valid,
  output logic [((clog2(NUM_BTN) > 0) ? clog2(NUM_BTN) : 1)-1:0] evt_id,
  output logic                              fifo_full,
  output logic [DROP_CNT_W-1:0]             drop_count
);

  localparam int IDW = (clog2(NUM_BTN) > 0) ? clog2(NUM_BTN) : 1;
  localparam int CW  = clog2(FIFO_DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_CNT_W) - 1;

  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] grant_vec;
  logic [NUM_BTN-1:0] drop_vec;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     head_id;
  logic               grant;
  logic               room;
  logic               pop;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  int                 drop_sum;

  assign evt_valid = !fifo_empty;
  assign evt_id    = evt_valid ? head_id : '0;
  assign pop       = evt_valid && evt_ready;
  assign room      = (fifo_count < CW'(FIFO_DEPTH)) || pop;

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_BTN; off++) begin
      cand = IDW'((int'(last_grant) + off) % NUM_BTN);
      if (room && !grant && pending[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vec = grant ? (NUM_BTN'(1) << grant_idx) : '0;
  end

  // A press on a button that is granted this cycle re-arms it instead of being lost.
  always_comb begin
    drop_vec = btn_pulse & pending & ~grant_vec;
    drop_sum = int'(drop_count);
    for (int i = 0; i < NUM_BTN; i++) drop_sum += int'(drop_vec[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      last_grant <= IDW'(NUM_BTN - 1);
      drop_count <= '0;
    end else begin
      pending <= (pending & ~grant_vec) | btn_pulse;
      if (grant) last_grant <= grant_idx;
      if (drop_clr)                drop_count <= '0;
      else if (drop_sum > DROP_MAX) drop_count <= DROP_CNT_W'(DROP_MAX);
      else                         drop_count <= DROP_CNT_W'(drop_sum);
    end
  end

  event_fifo #(
    .WIDTH (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (grant_idx),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
